instr_mem_loader: RTL

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/instr_mem_loader.sv
// Instruction memory loader.
// Collects a stream of program bytes, packs them little-endian into 32-bit
// words and writes each word to consecutive word addresses of the
// instruction memory, starting at BASE_ADDR. A load of len words is
// requested with start; done stays high until the next accepted start.
module instr_mem_loader #(
  parameter int                 ADDR_W    = 15,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data_in,
  output logic [7:0]        mem_mask_wren,
  output logic              mem_wren,
  output logic              mem_chip_sel,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

  state_t            state_reg, state_next;
  logic [ADDR_W:0]   len_reg, len_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [1:0]        idx_reg, idx_next;
  // Lower three bytes of the word being assembled; the fourth byte goes
  // straight into the write-data register on the closing transfer.
  logic [23:0]       word_reg, word_next;
  // Write data is kept separate from the assembly buffer so that the memory
  // data bus does not follow partial words while collecting.
  logic [31:0]       data_reg, data_next;

  logic              xfer;
  logic [2:0]        lane_hit;

  assign xfer = (state_reg == COLLECT) && byte_valid;

  // One strobe per lower byte lane: lane gi captures transfer index gi.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      assign lane_hit[gi] = xfer && (idx_reg == 2'(gi));
    end
  endgenerate

  // Next-state and datapath updates; every next value defaults to hold.
  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    count_next = count_reg;
    addr_next  = addr_reg;
    idx_next   = idx_reg;
    word_next  = word_reg;
    data_next  = data_reg;

    for (int i = 0; i < 3; i++) begin
      if (lane_hit[i]) begin
        word_next[8*i +: 8] = byte_in;
      end
    end

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          if (len != '0) begin
            len_next   = len;
            addr_next  = BASE_ADDR;
            idx_next   = 2'd0;
            count_next = '0;
            state_next = COLLECT;
          end else begin
            state_next = DONE;
          end
        end
      end
      COLLECT: begin
        if (byte_valid) begin
          idx_next = idx_reg + 2'd1;
          if (idx_reg == 2'd3) begin
            data_next  = {byte_in, word_reg};
            state_next = WRITE;
          end
        end
      end
      WRITE: begin
        addr_next  = addr_reg + ADDR_ONE;
        count_next = count_reg + COUNT_ONE;
        if ((count_reg + COUNT_ONE) == len_reg) begin
          state_next = DONE;
        end else begin
          state_next = COLLECT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      len_reg   <= '0;
      count_reg <= '0;
      addr_reg  <= BASE_ADDR;
      idx_reg   <= 2'd0;
      word_reg  <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      count_reg <= count_next;
      addr_reg  <= addr_next;
      idx_reg   <= idx_next;
      word_reg  <= word_next;
      data_reg  <= data_next;
    end
  end

  // Status and memory strobes are decoded from the state alone.
  always_comb begin
    byte_ready    = (state_reg == COLLECT);
    busy          = (state_reg == COLLECT) || (state_reg == WRITE);
    done          = (state_reg == DONE);
    mem_wren      = (state_reg == WRITE);
    mem_chip_sel  = (state_reg == WRITE);
    mem_mask_wren = {8{state_reg == WRITE}};
    mem_addr      = addr_reg;
    mem_data_in   = data_reg;
  end

endmodule
